// File: rtl/param_rx_if.sv
// Parameter bus and UART line between the PC receiver and the pulse generator.
// The receiver takes the slave side; the consumer/driver takes the master side.
interface param_rx_if;
    logic        rxd;
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_hf;
    logic        bl;
    logic        rx_done;
    logic        frame_err;
    logic        busy;

    modport slave (
        input  rxd,
        output per, p1wid, del, p2wid, nut_w, nut_d,
        output cp, p_bl, p_bl_hf, bl,
        output rx_done, frame_err, busy
    );

    modport master (
        output rxd,
        input  per, p1wid, del, p2wid, nut_w, nut_d,
        input  cp, p_bl, p_bl_hf, bl,
        input  rx_done, frame_err, busy
    );
endinterface

// File: rtl/param_rx.sv
// UART 8N1 receiver plus checksummed 20-byte frame parser that loads the
// pulse-sequence parameter set atomically.
module param_rx #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic      clk,
    input  logic      reset,
    param_rx_if.slave bus
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int TMO = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
    localparam int TW  = $clog2(TMO);

    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TLIM = TW'(TMO - 1);

    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_STOP  = 3'd3;
    localparam logic [2:0] R_WAIT  = 3'd4;

    localparam logic [1:0] P_HUNT = 2'd0;
    localparam logic [1:0] P_PAY  = 2'd1;
    localparam logic [1:0] P_CHK  = 2'd2;

    logic          rx_s1;
    logic          rx_s2;
    logic [2:0]    rs;
    logic [CW-1:0] cnt;
    logic [2:0]    nbit;
    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          byte_err;

    logic [1:0]    ps;
    logic [4:0]    idx;
    logic [7:0]    sum;
    logic [TW-1:0] tmo;
    logic [143:0]  shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rs         <= R_IDLE;
            cnt        <= '0;
            nbit       <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            rx_s1      <= bus.rxd;
            rx_s2      <= rx_s1;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            unique case (rs)
                R_IDLE: begin
                    if (!rx_s2) begin
                        rs  <= R_START;
                        cnt <= '0;
                    end
                end
                R_START: begin
                    // Mid start bit: a high line here was only a glitch.
                    if (cnt == HALF) begin
                        cnt  <= '0;
                        nbit <= '0;
                        rs   <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                        nbit    <= nbit + 1'b1;
                        if (nbit == 3'd7) rs <= R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                            rs         <= R_IDLE;
                        end else begin
                            byte_err <= 1'b1;
                            rs       <= R_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rx_s2) rs <= R_IDLE;
                end
                default: rs <= R_IDLE;
            endcase
        end
    end

    // Payload is shifted in MSB-first, so the first field lands on top.
    always_ff @(posedge clk) begin
        if (byte_valid && ps == P_PAY)
            shadow <= {shadow[135:0], rx_byte};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps            <= P_HUNT;
            idx           <= '0;
            sum           <= '0;
            tmo           <= '0;
            bus.rx_done   <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.per       <= 32'd4000;
            bus.p1wid     <= 16'd30;
            bus.del       <= 16'd200;
            bus.p2wid     <= 16'd60;
            bus.nut_w     <= 8'd0;
            bus.nut_d     <= 16'd0;
            bus.cp        <= 8'd1;
            bus.p_bl      <= 8'd100;
            bus.p_bl_hf   <= 16'd50;
            bus.bl        <= 1'b1;
        end else begin
            bus.rx_done   <= 1'b0;
            bus.frame_err <= 1'b0;
            unique case (ps)
                P_HUNT: begin
                    tmo <= '0;
                    if (byte_valid && rx_byte == 8'hA5) begin
                        ps  <= P_PAY;
                        idx <= '0;
                        sum <= '0;
                    end
                end
                P_PAY, P_CHK: begin
                    if (byte_err || (!byte_valid && tmo == TLIM)) begin
                        bus.frame_err <= 1'b1;
                        ps            <= P_HUNT;
                    end else if (byte_valid) begin
                        tmo <= '0;
                        if (ps == P_PAY) begin
                            sum <= sum + rx_byte;
                            idx <= idx + 1'b1;
                            if (idx == 5'd17) ps <= P_CHK;
                        end else begin
                            ps <= P_HUNT;
                            if (rx_byte == sum) begin
                                {bus.per, bus.p1wid, bus.del,
                                 bus.p2wid, bus.nut_w, bus.nut_d,
                                 bus.cp, bus.p_bl,
                                 bus.p_bl_hf} <= shadow[143:8];
                                bus.bl      <= shadow[0];
                                bus.rx_done <= 1'b1;
                            end else begin
                                bus.frame_err <= 1'b1;
                            end
                        end
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: ps <= P_HUNT;
            endcase
        end
    end

    assign bus.busy = (ps != P_HUNT);

endmodule

// File: tb/tb_param_rx.sv
// Bench for param_rx: UART frame driver, expected-event scoreboard and
// per-cycle parameter-bus check.
module tb_param_rx;

    localparam int CPB = 32;
    localparam int TOB = 4;

    typedef struct packed {
        logic [31:0] per;
        logic [15:0] p1wid;
        logic [15:0] del;
        logic [15:0] p2wid;
        logic [7:0]  nut_w;
        logic [15:0] nut_d;
        logic [7:0]  cp;
        logic [7:0]  p_bl;
        logic [15:0] p_bl_hf;
        logic        bl;
    } prm_t;

    localparam prm_t RST_P = '{per: 32'd4000, p1wid: 16'd30,
        del: 16'd200, p2wid: 16'd60, nut_w: 8'd0, nut_d: 16'd0,
        cp: 8'd1, p_bl: 8'd100, p_bl_hf: 16'd50, bl: 1'b1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    param_rx_if bus ();

    param_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BYTES(TOB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    prm_t got;
    assign got = {bus.per, bus.p1wid, bus.del, bus.p2wid, bus.nut_w,
                  bus.nut_d, bus.cp, bus.p_bl, bus.p_bl_hf, bus.bl};

    int   n_chk = 0;
    int   n_fail = 0;
    int   ev_q[$];
    prm_t pv_q[$];
    prm_t cur;
    logic [7:0] frm [20];

    task automatic chk(input string name, input logic [63:0] g,
                       input logic [63:0] e);
        n_chk++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, g, e);
        end
    endtask

    // Scoreboard: strobes must match the queued expectations in order,
    // and the parameter bus must equal the last accepted set every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            n_chk++;
            if (bus.rx_done && bus.frame_err) begin
                n_fail++;
                $display("FAIL strobes: rx_done and frame_err both high");
            end
            if (bus.rx_done) begin
                n_chk++;
                if (ev_q.size() == 0 || ev_q[0] != 0) begin
                    n_fail++;
                    $display("FAIL rx_done: got strobe, expected none");
                end else begin
                    cur = pv_q[0];
                end
                if (ev_q.size() != 0) begin
                    void'(ev_q.pop_front());
                    void'(pv_q.pop_front());
                end
            end
            if (bus.frame_err) begin
                n_chk++;
                if (ev_q.size() == 0 || ev_q[0] != 1) begin
                    n_fail++;
                    $display("FAIL frame_err: got strobe, expected none");
                end
                if (ev_q.size() != 0) begin
                    void'(ev_q.pop_front());
                    void'(pv_q.pop_front());
                end
            end
            n_chk++;
            if (got !== cur) begin
                n_fail++;
                $display("FAIL params: got %h expected %h", got, cur);
            end
        end
    end

    task automatic build(input prm_t p, input logic [6:0] bl_hi);
        logic [143:0] pl;
        int s;
        pl = {p.per, p.p1wid, p.del, p.p2wid, p.nut_w, p.nut_d,
              p.cp, p.p_bl, p.p_bl_hf, bl_hi, p.bl};
        s = 0;
        frm[0] = 8'hA5;
        for (int i = 0; i < 18; i++) begin
            frm[i+1] = pl[143-8*i -: 8];
            s += int'(frm[i+1]);
        end
        frm[19] = 8'(s % 256);
    endtask

    task automatic expect_ev(input int kind, input prm_t p);
        ev_q.push_back(kind);
        pv_q.push_back(p);
    endtask

    task automatic bit_time();
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        bus.rxd = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            bit_time();
        end
        bus.rxd = stop_ok;
        bit_time();
        bus.rxd = 1'b1;
        if (!stop_ok) bit_time();
    endtask

    task automatic send_range(input int lo, input int hi, input int bad);
        for (int i = lo; i <= hi; i++) send_byte(frm[i], i != bad);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && ev_q.size() != 0; i++)
            @(negedge clk);
        chk(name, 64'(ev_q.size()), 64'd0);
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    prm_t p, q, r;
    logic [159:0] rr;
    logic [7:0] bad_ck;

    initial begin
        bus.rxd = 1'b1;
        cur = RST_P;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_per", 64'(bus.per), 64'd4000);
        chk("rst_p1wid", 64'(bus.p1wid), 64'd30);
        chk("rst_cp", 64'(bus.cp), 64'd1);
        chk("rst_p_bl_hf", 64'(bus.p_bl_hf), 64'd50);
        chk("rst_bl", 64'(bus.bl), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rx_done", 64'(bus.rx_done), 64'd0);

        // Nominal frame
        p = '{per: 32'h1F40, p1wid: 16'd40, del: 16'd150,
              p2wid: 16'd80, nut_w: 8'd5, nut_d: 16'd10, cp: 8'd3,
              p_bl: 8'd60, p_bl_hf: 16'd30, bl: 1'b0};
        build(p, 7'd0);
        chk("model_cksum", 64'(frm[19]), 64'hD9);
        expect_ev(0, p);
        send_range(0, 19, -1);
        drain("valid_frame", 500);
        chk("lit_per", 64'(bus.per), 64'd8000);
        chk("lit_p1wid", 64'(bus.p1wid), 64'd40);
        chk("lit_del", 64'(bus.del), 64'd150);
        chk("lit_cp", 64'(bus.cp), 64'd3);
        chk("lit_bl", 64'(bus.bl), 64'd0);

        // Bad checksum: outputs must stay put
        q = p;
        q.per = 32'd12345;
        build(q, 7'd0);
        frm[19] = frm[19] + 8'd1;
        expect_ev(1, q);
        send_range(0, 19, -1);
        drain("bad_cksum", 500);
        chk("bad_cksum_per", 64'(bus.per), 64'd8000);

        // Garbage before a frame
        q = p;
        q.nut_w = 8'd7;
        q.per = 32'hDEAD_BEEF;
        build(q, 7'd0);
        expect_ev(0, q);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_range(0, 19, -1);
        drain("garbage_then_frame", 500);

        // Stop-bit error mid-payload, then recovery with cp = 0
        build(p, 7'd0);
        expect_ev(1, p);
        send_range(0, 5, 5);
        drain("stop_err", 500);
        q = p;
        q.cp = 8'd0;
        build(q, 7'd0);
        expect_ev(0, q);
        send_range(0, 19, -1);
        drain("after_stop_err", 500);
        chk("lit_cp0", 64'(bus.cp), 64'd0);

        // Short glitch between payload bytes must not add a byte
        r = p;
        r.del = 16'd777;
        r.bl = 1'b1;
        build(r, 7'd0);
        expect_ev(0, r);
        send_range(0, 10, -1);
        repeat (3 * CPB) @(negedge clk);
        chk("busy_mid_frame", 64'(bus.busy), 64'd1);
        bus.rxd = 1'b0;
        repeat (8) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_range(11, 19, -1);
        drain("glitch_frame", 500);

        // Halted frame: timeout abort
        build(p, 7'd0);
        expect_ev(1, p);
        send_range(0, 9, -1);
        @(negedge clk);
        chk("busy_halted", 64'(bus.busy), 64'd1);
        drain("timeout", TOB * 10 * CPB + 200);
        chk("busy_after_timeout", 64'(bus.busy), 64'd0);

        // Reset in the middle of a frame
        q = p;
        q.per = 32'd99;
        build(q, 7'd0);
        send_range(0, 7, -1);
        chk("busy_before_reset", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        cur = RST_P;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_per", 64'(bus.per), 64'd4000);
        chk("reset_del", 64'(bus.del), 64'd200);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        build(r, 7'd0);
        expect_ev(0, r);
        send_range(0, 19, -1);
        drain("after_reset", 500);

        // Random frames, random bl padding bits, occasional bad checksum
        for (int k = 0; k < 3; k++) begin
            rr = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom()};
            q = rr[136:0];
            build(q, 7'($urandom_range(0, 127)));
            if ($urandom_range(0, 3) == 0) begin
                bad_ck = frm[19] ^ 8'h01;
                frm[19] = bad_ck;
                expect_ev(1, q);
            end else begin
                expect_ev(0, q);
            end
            send_range(0, 19, -1);
            drain("random_frame", 500);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/param_rx.md
# param_rx

Serial command receiver that loads the pulse-sequence parameter set from the PC over a UART line. It decodes 8N1 bytes on `rxd`, parses a fixed-length checksummed frame, and presents the parameter bus consumed by the pulse generator (`per`, `p1wid`, `del`, `p2wid`, `nut_w`, `nut_d`, `cp`, `p_bl`, `p_bl_hf`, `bl`). All parameters update atomically, and a one-cycle `rx_done` strobe marks each update. It runs in the 50 MHz `clk` domain, alongside the pulse generator's slow-clock block.

## Interface
- `CLKS_PER_BIT`, default 434: clocks per UART bit (50 MHz / 115200); legal range ≥ 4.
- `TIMEOUT_BYTES`, default 4: idle byte-times allowed between bytes of one frame before the parser abandons the frame.
- `clk`  in  1  50 MHz system clock. One clock domain only.
- `reset`  in  1  Synchronous, active-high reset.
- `rxd`  in  1  UART receive line; asynchronous; idles high.
- `per`  out  32  Period, in clk_pll cycles.
- `p1wid`  out  16  Width of pulse 1.
- `del`  out  16  Delay between pulses.
- `p2wid`  out  16  Width of pulse 2 / CPMG pulses.
- `nut_w`  out  8  Width of the nutation pulse.
- `nut_d`  out  16  Nutation pulse delay.
- `cp`  out  8  CPMG setting: 0 = CW, 1 = Hahn echo, N = N-pulse CPMG.
- `p_bl`  out  8  Block window length.
- `p_bl_hf`  out  16  Half block window.
- `bl`  out  1  Blocking enable.
- `rx_done`  out  1  One-cycle strobe; parameter outputs changed this cycle.
- `frame_err`  out  1  One-cycle strobe; frame discarded.
- `busy`  out  1  High while a frame is in progress (parser not in HUNT).

## Operation
**Reset values**
- `per` = 4000, `p1wid` = 30, `del` = 200, `p2wid` = 60, `nut_w` = 0, `nut_d` = 0, `cp` = 1, `p_bl` = 100, `p_bl_hf` = 50, `bl` = 1.
- `rx_done`, `frame_err` and `busy` reset to 0.
- Reset asserted mid-byte or mid-frame discards everything received so far and returns the parser to HUNT.

**Byte receiver**
- `rxd` passes through a 2-FF synchronizer before any use.
- IDLE: a low on the synchronized line starts the bit counter.
- At count `CLKS_PER_BIT/2`, the line is sampled:
  - still low: the start bit is valid;
  - high: the event is a glitch; return to IDLE with no error.
- Eight data bits follow, LSB first, each sampled every `CLKS_PER_BIT` clocks at bit centre.
- The stop bit is sampled one bit-time later:
  - high: emit `byte_valid` (internal, 1 cycle) with the data;
  - low: emit `byte_err`, then wait for the line to return high before leaving to IDLE.

**Frame format (20 bytes)**
- Byte 0: header 0xA5.
- Bytes 1–18: payload, multi-byte fields MSB first, in this order:
  - `per`: 4 bytes;
  - `p1wid`, `del`, `p2wid`: 2 bytes each;
  - `nut_w`: 1 byte;
  - `nut_d`: 2 bytes;
  - `cp`, `p_bl`: 1 byte each;
  - `p_bl_hf`: 2 bytes;
  - `bl`: 1 byte; only bit 0 is used.
- Byte 19: checksum = (sum of bytes 1–18) mod 256. The header is excluded; all 8 bits of every payload byte, including the `bl` byte, are summed.

**Parser FSM**
- HUNT:
  - `byte_valid` with 0xA5 → PAYLOAD; index = 0, sum = 0.
  - Any other byte is ignored; no error is flagged.
- PAYLOAD:
  - Each `byte_valid` writes shadow[index] and adds the byte to the 8-bit sum (wraps).
  - After index 17 is written → CHECK.
- CHECK, on `byte_valid`:
  - checksum == sum: copy shadow to the outputs, pulse `rx_done`, go to HUNT.
  - mismatch: pulse `frame_err`, outputs unchanged, go to HUNT.
- In PAYLOAD or CHECK, the frame is aborted with a `frame_err` pulse and a return to HUNT when either occurs:
  - `byte_err`;
  - no `byte_valid` for `TIMEOUT_BYTES*10*CLKS_PER_BIT` clocks.
- In HUNT, `byte_err` is silent.
- A 0xA5 inside the payload is ordinary data; the parser does not resynchronize on it.
- Output registers are written only on a successful CHECK; no partial update is ever visible.

## Timing
- `byte_valid` fires in the clock of the stop-bit sample: 2 (sync) + `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT` clocks after the falling edge of the start bit.
- Outputs and `rx_done` update on the clock edge after the checksum byte's `byte_valid`, i.e. 1-cycle parser latency.
- `rx_done` and the new values are visible in the same cycle; `rx_done` is high for exactly 1 cycle.
- `frame_err` fires 1 cycle after the causing event and is high for exactly 1 cycle.
- `rx_done` and `frame_err` are never high together.
- Back-to-back frames with no idle gap are accepted: a start bit arriving directly after a stop bit is detected.
- The timeout counter restarts on every `byte_valid`.
- Consumers may sample the parameters on any cycle; they are held constant between `rx_done` strobes.

## Test plan
- Reset, no traffic → all outputs equal the reset values listed above; `rx_done` = 0, `busy` = 0.
- Valid frame: `per` = 0x00001F40, `p1wid` = 40, `del` = 150, `p2wid` = 80, `nut_w` = 5, `nut_d` = 10, `cp` = 3, `p_bl` = 60, `p_bl_hf` = 30, `bl` = 0, correct checksum → exactly one `rx_done`; all ten fields match, with `per` = 8000.
- Same frame with checksum +1 → one `frame_err`; outputs keep their previous values.
- Garbage bytes 0x00, 0x13, 0xFF, then a valid frame → no errors; one `rx_done`; fields loaded.
- Stop bit forced low on payload byte 5 → `frame_err`. Then the same valid frame with `cp` = 0 → `rx_done` and `cp` = 0.
- 8-clock low glitch on `rxd` with `CLKS_PER_BIT` = 32 → no byte decoded. Separately, frame halted after 10 bytes → `frame_err` after the timeout; `busy` falls. Also, `reset` asserted mid-frame → reset values restored; the next full frame loads correctly.
